// File: rtl/ms_sync_source.sv
// Master-side producer: buffers upstream values in a FIFO and releases one per
// period tick onto s_out, strobing s_out_sync for the cycle the value changes.
module ms_sync_source #(
   parameter int unsigned PERIOD = 4,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned UCNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic signed [31:0]       in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [31:0]       s_out,
   output logic                     s_out_sync,
   output logic [UCNT_W-1:0]        underrun_cnt,
   output logic                     phase
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   typedef enum logic {
      SECTION_A = 1'b0,
      SECTION_B = 1'b1
   } phase_t;

   phase_t             state_q;
   logic [CW-1:0]      cnt;
   logic [31:0]        mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        fill;
   logic               tick;
   logic               push;
   logic               pop;

   // Pop decisions use the registered fill level, so a value pushed on a tick
   // edge is never released by that same tick.
   assign tick     = en && (cnt == CW'(PERIOD - 1));
   assign in_ready = (fill < (AW + 1)'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = tick && (fill != '0);
   assign phase    = (state_q == SECTION_B);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= SECTION_A;
         cnt          <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fill         <= '0;
         s_out        <= '0;
         s_out_sync   <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         if (push && !pop)      fill <= fill + 1'b1;
         else if (pop && !push) fill <= fill - 1'b1;

         s_out_sync <= pop;
         if (pop) s_out <= mem[rd_ptr];

         if (!en || tick) cnt <= '0;
         else             cnt <= cnt + 1'b1;

         if ((state_q == SECTION_B) && tick && (fill == '0) && (underrun_cnt != '1))
            underrun_cnt <= underrun_cnt + 1'b1;

         case (state_q)
            SECTION_A: if (pop) state_q <= SECTION_B;
            SECTION_B: if (!en) state_q <= SECTION_A;
            default:   state_q <= SECTION_A;
         endcase
      end
   end

endmodule

// File: tb/tb_ms_sync_source.sv
// Scoreboard bench for ms_sync_source: a PERIOD=4/UCNT_W=2 instance for the
// priming, underrun, backpressure and reset cases, and a PERIOD=1 streaming instance.
module tb_ms_sync_source;

   logic               clk;
   logic               rst;

   logic               en_a;
   logic signed [31:0] in_data_a;
   logic               in_valid_a;
   logic               in_ready_a;
   logic signed [31:0] s_out_a;
   logic               s_out_sync_a;
   logic [1:0]         underrun_cnt_a;
   logic               phase_a;

   logic               en_b;
   logic signed [31:0] in_data_b;
   logic               in_valid_b;
   logic               in_ready_b;
   logic signed [31:0] s_out_b;
   logic               s_out_sync_b;
   logic [15:0]        underrun_cnt_b;
   logic               phase_b;

   int                 n_checks = 0;
   int                 n_errors = 0;
   int                 q_a[$];
   int                 q_b[$];
   int                 last_a = 0;
   int                 last_b = 0;

   ms_sync_source #(.PERIOD(4), .DEPTH(4), .UCNT_W(2)) u_dut_p4 (
      .clk(clk), .rst(rst), .en(en_a), .in_data(in_data_a), .in_valid(in_valid_a),
      .in_ready(in_ready_a), .s_out(s_out_a), .s_out_sync(s_out_sync_a),
      .underrun_cnt(underrun_cnt_a), .phase(phase_a)
   );

   ms_sync_source #(.PERIOD(1), .DEPTH(4), .UCNT_W(16)) u_dut_p1 (
      .clk(clk), .rst(rst), .en(en_b), .in_data(in_data_b), .in_valid(in_valid_b),
      .in_ready(in_ready_b), .s_out(s_out_b), .s_out_sync(s_out_sync_b),
      .underrun_cnt(underrun_cnt_b), .phase(phase_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock on the PERIOD=4 instance; accepted pushes go to the scoreboard.
   task automatic step_a(input bit exp_ready, input bit exp_sync);
      check("in_ready_a", in_ready_a, exp_ready);
      if (in_valid_a && exp_ready) q_a.push_back(in_data_a);
      @(posedge clk); #1;
      check("s_out_sync_a", s_out_sync_a, exp_sync);
      if (exp_sync) last_a = (q_a.size() > 0) ? q_a.pop_front() : 32'h0BAD0BAD;
      check("s_out_a", s_out_a, last_a);
   endtask

   task automatic step_b(input bit exp_ready, input bit exp_sync);
      check("in_ready_b", in_ready_b, exp_ready);
      if (in_valid_b && exp_ready) q_b.push_back(in_data_b);
      @(posedge clk); #1;
      check("s_out_sync_b", s_out_sync_b, exp_sync);
      if (exp_sync) last_b = (q_b.size() > 0) ? q_b.pop_front() : 32'h0BAD0BAD;
      check("s_out_b", s_out_b, last_b);
   endtask

   initial begin
      int ue;
      int vals[5];
      vals = '{1, 2, 3, 4, -7};
      rst = 1'b1;
      en_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
      en_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
      #12;
      check("rst_s_out", s_out_a, 0);
      check("rst_sync", s_out_sync_a, 0);
      check("rst_ucnt", underrun_cnt_a, 0);
      check("rst_phase", phase_a, 0);
      check("rst_ready", in_ready_a, 1);
      check("rst_phase_b", phase_b, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Priming, three releases, then underruns saturating at 3
      en_a = 1'b1;
      for (int e = 1; e <= 33; e++) begin
         in_valid_a = (e <= 3);
         in_data_a  = e * 10;
         step_a(1'b1, (e % 4 == 0) && (e <= 12));
         if (e == 3) check("phase_priming", phase_a, 0);
         if (e == 4) check("phase_run", phase_a, 1);
         if ((e % 4 == 0) && (e >= 16)) begin
            ue = e / 4 - 3;
            if (ue > 3) ue = 3;
            check("underrun_cnt", underrun_cnt_a, ue);
         end
      end
      in_valid_a = 1'b0;

      // Dropping en mid-period returns to priming and restarts the period
      en_a = 1'b0;
      step_a(1'b1, 1'b0);
      check("phase_en_low", phase_a, 0);
      check("ucnt_hold", underrun_cnt_a, 3);
      en_a = 1'b1; in_valid_a = 1'b1; in_data_a = 99;
      step_a(1'b1, 1'b0);
      in_valid_a = 1'b0;
      step_a(1'b1, 1'b0);
      step_a(1'b1, 1'b0);
      step_a(1'b1, 1'b1);
      check("phase_rerun", phase_a, 1);
      check("ucnt_sat_kept", underrun_cnt_a, 3);

      // Backpressure with a full FIFO
      en_a = 1'b0;
      step_a(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         in_valid_a = 1'b1;
         in_data_a  = vals[i];
         step_a(1'b1, 1'b0);
      end
      in_data_a = vals[4];
      step_a(1'b0, 1'b0);
      step_a(1'b0, 1'b0);
      en_a = 1'b1;
      repeat (3) step_a(1'b0, 1'b0);
      step_a(1'b0, 1'b1);
      step_a(1'b1, 1'b0);
      in_valid_a = 1'b0;
      step_a(1'b0, 1'b0);
      step_a(1'b0, 1'b0);
      step_a(1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         repeat (3) step_a(1'b1, 1'b0);
         step_a(1'b1, 1'b1);
      end
      check("fifo_drained", q_a.size(), 0);

      // Asynchronous reset with three entries queued
      for (int i = 0; i < 3; i++) begin
         in_valid_a = 1'b1;
         in_data_a  = 11 + i;
         step_a(1'b1, 1'b0);
      end
      in_valid_a = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_s_out", s_out_a, 0);
      check("mid_rst_sync", s_out_sync_a, 0);
      check("mid_rst_ucnt", underrun_cnt_a, 0);
      check("mid_rst_phase", phase_a, 0);
      check("mid_rst_ready", in_ready_a, 1);
      q_a.delete();
      last_a = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) step_a(1'b1, 1'b0);
      check("post_rst_phase", phase_a, 0);
      check("post_rst_ucnt", underrun_cnt_a, 0);
      en_a = 1'b0;

      // PERIOD=1 streaming: strobe held high while the stream keeps up
      en_b = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         in_valid_b = 1'b1;
         in_data_b  = i;
         step_b(1'b1, i >= 2);
         check("stream_ucnt", underrun_cnt_b, 0);
      end
      in_valid_b = 1'b0;
      step_b(1'b1, 1'b1);
      check("stream_ucnt_last", underrun_cnt_b, 0);
      check("stream_phase", phase_b, 1);
      step_b(1'b1, 1'b0);
      check("stream_underrun", underrun_cnt_b, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
